// File: rtl/zynq_axil_csr_pkg.sv
// Shared types and address-decode helpers for the PS-facing AXI4-Lite CSR responder.
package zynq_axil_csr_pkg;

    typedef enum logic [1:0] {
        e_axil_okay   = 2'b00,
        e_axil_slverr = 2'b10
    } axil_resp_e;

    // Word index of a byte address; the two byte-offset bits are dropped.
    function automatic logic [31:0] idx_of(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    // The FIFO occupancy and data registers sit directly above the RW CSR words.
    function automatic int unsigned count_idx_of(input int unsigned num_regs);
        return num_regs;
    endfunction

    function automatic int unsigned data_idx_of(input int unsigned num_regs);
        return num_regs + 1;
    endfunction

endpackage

// File: rtl/zynq_axil_csr_responder_fifo.sv
// Small power-of-two PL->PS FIFO with valid/ready enqueue, yumi dequeue and occupancy count.
module bsg_fifo_1r1w_small #(
    parameter int els_p   = 4,
    parameter int width_p = 32,
    localparam int ptr_w  = $clog2(els_p),
    localparam int cnt_w  = $clog2(els_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [cnt_w-1:0]   count_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w-1:0]   count_q, count_d;
    logic               enq, deq;

    assign ready_o = (count_q != cnt_w'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wptr_d  = wptr_q + ptr_w'(enq);
        rptr_d  = rptr_q + ptr_w'(deq);
        count_d = count_q + cnt_w'(enq) - cnt_w'(deq);
    end

    // NOTE: state registers use <= so all flops update together from pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/zynq_axil_csr_responder.sv
// AXI4-Lite responder for the PS s00_axi port: RW CSR words plus a PL->PS FIFO exposed as count/data.
module zynq_axil_csr_responder
    import zynq_axil_csr_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int data_width_p = 32,
    parameter int num_regs_p   = 16,
    parameter int fifo_els_p   = 4
) (
    input  logic                               aclk_i,
    input  logic                               areset_i,
    input  logic [addr_width_p-1:0]            awaddr_i,
    input  logic [2:0]                         awprot_i,
    input  logic                               awvalid_i,
    output logic                               awready_o,
    input  logic [data_width_p-1:0]            wdata_i,
    input  logic [data_width_p/8-1:0]          wstrb_i,
    input  logic                               wvalid_i,
    output logic                               wready_o,
    output logic [1:0]                         bresp_o,
    output logic                               bvalid_o,
    input  logic                               bready_i,
    input  logic [addr_width_p-1:0]            araddr_i,
    input  logic [2:0]                         arprot_i,
    input  logic                               arvalid_i,
    output logic                               arready_o,
    output logic [data_width_p-1:0]            rdata_o,
    output logic [1:0]                         rresp_o,
    output logic                               rvalid_o,
    input  logic                               rready_i,
    output logic [num_regs_p*data_width_p-1:0] csr_o,
    input  logic                               in_v_i,
    input  logic [data_width_p-1:0]            in_data_i,
    output logic                               in_ready_o
);

    localparam int idx_w  = addr_width_p - 2;
    localparam int sel_w  = $clog2(num_regs_p);
    localparam int cnt_w  = $clog2(fifo_els_p + 1);
    localparam int strb_w = data_width_p / 8;
    localparam logic [idx_w-1:0] count_idx = idx_w'(count_idx_of(num_regs_p));
    localparam logic [idx_w-1:0] data_idx  = idx_w'(data_idx_of(num_regs_p));

    logic                    aw_v_q, aw_v_d, w_v_q, w_v_d, b_v_q, b_v_d, r_v_q, r_v_d;
    logic [idx_w-1:0]        aw_idx_q, aw_idx_d;
    logic [data_width_p-1:0] w_data_q, w_data_d, r_data_q, r_data_d;
    logic [strb_w-1:0]       w_strb_q, w_strb_d;
    axil_resp_e              b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic [data_width_p-1:0] csr_q [num_regs_p];
    logic [data_width_p-1:0] csr_d [num_regs_p];

    logic [idx_w-1:0]        aw_idx_in, ar_idx;
    logic                    aw_hs, w_hs, ar_hs, commit, pop;
    logic                    fifo_v;
    logic [data_width_p-1:0] fifo_data;
    logic [cnt_w-1:0]        fifo_count;
    logic                    unused_prot;

    assign unused_prot = ^{awprot_i, arprot_i};
    assign aw_idx_in   = idx_w'(idx_of(32'(awaddr_i)));
    assign ar_idx      = idx_w'(idx_of(32'(araddr_i)));

    assign awready_o = ~aw_v_q;
    assign wready_o  = ~w_v_q;
    assign arready_o = ~r_v_q;
    assign bvalid_o  = b_v_q;
    assign bresp_o   = b_resp_q;
    assign rvalid_o  = r_v_q;
    assign rdata_o   = r_data_q;
    assign rresp_o   = r_resp_q;

    assign aw_hs  = awvalid_i & ~aw_v_q;
    assign w_hs   = wvalid_i & ~w_v_q;
    assign ar_hs  = arvalid_i & ~r_v_q;
    assign commit = aw_v_q & w_v_q & ~b_v_q;
    assign pop    = ar_hs & (ar_idx == data_idx) & fifo_v;

    for (genvar k = 0; k < num_regs_p; k++) begin : g_csr_out
        assign csr_o[k*data_width_p +: data_width_p] = csr_q[k];
    end

    always_comb begin
        aw_v_d   = aw_v_q;
        aw_idx_d = aw_idx_q;
        w_v_d    = w_v_q;
        w_data_d = w_data_q;
        w_strb_d = w_strb_q;
        b_v_d    = b_v_q;
        b_resp_d = b_resp_q;
        csr_d    = csr_q;

        if (aw_hs) begin
            aw_v_d   = 1'b1;
            aw_idx_d = aw_idx_in;
        end
        if (w_hs) begin
            w_v_d    = 1'b1;
            w_data_d = wdata_i;
            w_strb_d = wstrb_i;
        end
        if (b_v_q & bready_i) b_v_d = 1'b0;

        // Buffers cannot refill in the commit cycle since their readies are low while full.
        if (commit) begin
            aw_v_d   = 1'b0;
            w_v_d    = 1'b0;
            b_v_d    = 1'b1;
            b_resp_d = e_axil_slverr;
            if (aw_idx_q < count_idx) begin
                b_resp_d = e_axil_okay;
                for (int b = 0; b < strb_w; b++) begin
                    if (w_strb_q[b]) csr_d[aw_idx_q[sel_w-1:0]][8*b +: 8] = w_data_q[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        r_v_d    = r_v_q;
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;

        if (r_v_q & rready_i) r_v_d = 1'b0;

        // CSR reads see csr_q, so a same-cycle commit to that word returns the old value.
        if (ar_hs) begin
            r_v_d    = 1'b1;
            r_data_d = '0;
            r_resp_d = e_axil_slverr;
            if (ar_idx < count_idx) begin
                r_data_d = csr_q[ar_idx[sel_w-1:0]];
                r_resp_d = e_axil_okay;
            end else if (ar_idx == count_idx) begin
                r_data_d = data_width_p'(fifo_count);
                r_resp_d = e_axil_okay;
            end else if ((ar_idx == data_idx) && fifo_v) begin
                r_data_d = fifo_data;
                r_resp_d = e_axil_okay;
            end
        end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            aw_v_q   <= 1'b0;
            aw_idx_q <= '0;
            w_v_q    <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            b_v_q    <= 1'b0;
            b_resp_q <= e_axil_okay;
            r_v_q    <= 1'b0;
            r_data_q <= '0;
            r_resp_q <= e_axil_okay;
            for (int k = 0; k < num_regs_p; k++) csr_q[k] <= '0;
        end else begin
            aw_v_q   <= aw_v_d;
            aw_idx_q <= aw_idx_d;
            w_v_q    <= w_v_d;
            w_data_q <= w_data_d;
            w_strb_q <= w_strb_d;
            b_v_q    <= b_v_d;
            b_resp_q <= b_resp_d;
            r_v_q    <= r_v_d;
            r_data_q <= r_data_d;
            r_resp_q <= r_resp_d;
            csr_q    <= csr_d;
        end
    end

    bsg_fifo_1r1w_small #(
        .els_p   (fifo_els_p),
        .width_p (data_width_p)
    ) u_fifo (
        .clk_i   (aclk_i),
        .reset_i (areset_i),
        .v_i     (in_v_i),
        .data_i  (in_data_i),
        .ready_o (in_ready_o),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (pop),
        .count_o (fifo_count)
    );

endmodule
